// File: rtl/mem_sram_ctrl_pkg.sv
// mem_sram_ctrl_pkg: shared state encoding and defaults for the SRAM data-memory controller
package mem_sram_ctrl_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE} state_e;
    localparam int DEF_BASE_ADDR     = 1024;
    localparam int DEF_ACCESS_CYCLES = 3;
    localparam int CNT_W             = 4;
endpackage

// File: rtl/mem_sram_ctrl_phase_counter.sv
// sram_phase_counter: per-phase cycle counter with clear and terminal-count flag
module sram_phase_counter
    import mem_sram_ctrl_pkg::*;
#(
    parameter int TERM = DEF_ACCESS_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic last_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // next count: restart on clear, otherwise advance
    always_comb cnt_d = clr_i ? '0 : cnt_q + 1'b1;
    // count register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign last_o = cnt_q == CNT_W'(TERM - 1);
endmodule

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: splits a 32-bit load/store into two half-word SRAM accesses and stalls the pipeline meanwhile
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter int BIT_NUMBER    = 32,
    parameter int SRAM_ADDR_W   = 18,
    parameter int BASE_ADDR     = DEF_BASE_ADDR,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [BIT_NUMBER-1:0]  address,
    input  logic [BIT_NUMBER-1:0]  write_data,
    output logic [BIT_NUMBER-1:0]  read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);
    localparam int WORD_W = SRAM_ADDR_W - 1;

    state_e                  state_q, state_d;
    logic                    req, last, phase, hi;
    logic [BIT_NUMBER-1:0]   off;
    logic                    unused_off;
    logic [WORD_W-1:0]       word_q;
    logic [BIT_NUMBER-1:0]   data_q;
    logic                    wr_q;
    logic [15:0]             cap_lo_q;
    logic [SRAM_ADDR_W-1:0]  addr_hold_q;
    logic [15:0]             dq_hold_q;
    logic [BIT_NUMBER-1:0]   read_data_q;

    assign req   = rd_en | wr_en;
    assign phase = state_q == ST_LO || state_q == ST_HI;
    assign hi    = state_q == ST_HI;
    // word offset from the SRAM window; low-address wrap is intentional
    assign off        = address - BIT_NUMBER'(BASE_ADDR);
    assign unused_off = ^{off[BIT_NUMBER-1:SRAM_ADDR_W+1], off[1:0]};

    sram_phase_counter #(.TERM(ACCESS_CYCLES)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (!phase || last),
        .last_o (last)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else state_q <= state_d;
    end

    // next state: accept, low half, high half, one release cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = req ? ST_LO : ST_IDLE;
            ST_LO:   state_d = last ? ST_HI : ST_LO;
            ST_HI:   state_d = last ? ST_DONE : ST_HI;
            default: state_d = ST_IDLE;
        endcase
    end

    // bus outputs; address and data hold their last driven value between phases
    always_comb begin
        ready       = state_q == ST_IDLE ? !req : state_q == ST_DONE;
        sram_addr   = phase ? {word_q, hi} : addr_hold_q;
        sram_dq_out = phase ? (hi ? data_q[31:16] : data_q[15:0]) : dq_hold_q;
        sram_dq_oe  = phase && wr_q;
        sram_we_n   = !(phase && wr_q && !last);
    end

    // request latch, bus hold registers and read capture
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q      <= '0;
            data_q      <= '0;
            wr_q        <= 1'b0;
            cap_lo_q    <= '0;
            addr_hold_q <= '0;
            dq_hold_q   <= '0;
            read_data_q <= '0;
        end else begin
            if (state_q == ST_IDLE && req) begin
                word_q <= off[SRAM_ADDR_W:2];
                data_q <= write_data;
                wr_q   <= wr_en;
            end
            addr_hold_q <= sram_addr;
            dq_hold_q   <= sram_dq_out;
            if (phase && !hi && !wr_q && last) cap_lo_q <= sram_dq_in;
            if (hi && !wr_q && last) read_data_q <= {sram_dq_in, cap_lo_q};
        end
    end

    assign read_data = read_data_q;
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: directed checks of the two-half-word SRAM controller against a behavioural SRAM
module tb_mem_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic [15:0] mem [0:(1<<18)-1];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_sram_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
    assign sram_dq_in = mem[sram_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag, input logic [31:0] exp_rd, input logic [17:0] exp_sa);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
        chk({tag, "_oe"}, 32'(sram_dq_oe), 32'd0);
        chk({tag, "_rdata"}, read_data, exp_rd);
        chk({tag, "_saddr"}, 32'(sram_addr), 32'(exp_sa));
    endtask

    // present a request in the current IDLE cycle and walk it to DONE (cycle 7)
    task automatic access(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [17:0] sa, input logic [31:0] prev,
                          input logic [31:0] exp_rd);
        rd_en = rd;
        wr_en = wr;
        address = a;
        write_data = d;
        #1;
        chk({tag, "_ready_c0"}, 32'(ready), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k < 7) begin
                chk($sformatf("%s_ready_c%0d", tag, k), 32'(ready), 32'd0);
                chk($sformatf("%s_saddr_c%0d", tag, k), 32'(sram_addr), 32'(sa) + ((k > 3) ? 32'd1 : 32'd0));
                chk($sformatf("%s_oe_c%0d", tag, k), 32'(sram_dq_oe), 32'(wr));
                chk($sformatf("%s_we_n_c%0d", tag, k), 32'(sram_we_n), (wr && k != 3 && k != 6) ? 32'd0 : 32'd1);
                chk($sformatf("%s_rdata_c%0d", tag, k), read_data, prev);
                if (wr) chk($sformatf("%s_dq_c%0d", tag, k), 32'(sram_dq_out), (k > 3) ? 32'(d[31:16]) : 32'(d[15:0]));
            end else begin
                chk({tag, "_ready_done"}, 32'(ready), 32'd1);
                chk({tag, "_we_n_done"}, 32'(sram_we_n), 32'd1);
                chk({tag, "_oe_done"}, 32'(sram_dq_oe), 32'd0);
                chk({tag, "_rdata_done"}, read_data, exp_rd);
            end
        end
    endtask

    task automatic release_req();
        step();
        rd_en = 1'b0;
        wr_en = 1'b0;
        #1;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        #1;
        idle_chk("reset", 32'h0, 18'h0);

        access("st1032", 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4, 32'h0, 32'h0);
        release_req();
        chk("mem4", 32'(mem[4]), 32'h0000BEEF);
        chk("mem5", 32'(mem[5]), 32'h0000DEAD);
        idle_chk("after_st", 32'h0, 18'd5);

        access("ld1032", 1'b1, 1'b0, 32'd1032, 32'h0, 18'd4, 32'h0, 32'hDEADBEEF);
        release_req();
        idle_chk("after_ld", 32'hDEADBEEF, 18'd5);

        access("b2b_ld", 1'b1, 1'b0, 32'd1032, 32'h0, 18'd4, 32'hDEADBEEF, 32'hDEADBEEF);
        step();
        access("b2b_st", 1'b0, 1'b1, 32'd1036, 32'h12345678, 18'd6, 32'hDEADBEEF, 32'hDEADBEEF);
        release_req();
        chk("mem6", 32'(mem[6]), 32'h00005678);
        chk("mem7", 32'(mem[7]), 32'h00001234);

        access("both", 1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 18'd8, 32'hDEADBEEF, 32'hDEADBEEF);
        release_req();
        chk("mem8", 32'(mem[8]), 32'h0000F00D);
        chk("mem9", 32'(mem[9]), 32'h0000CAFE);
        access("ld1040", 1'b1, 1'b0, 32'd1040, 32'h0, 18'd8, 32'hDEADBEEF, 32'hCAFEF00D);
        release_req();

        access("wrap", 1'b0, 1'b1, 32'd1022, 32'hA5A55A5A, 18'h3FFFE, 32'hCAFEF00D, 32'hCAFEF00D);
        release_req();
        chk("mem_wrap_lo", 32'(mem[18'h3FFFE]), 32'h00005A5A);
        chk("mem_wrap_hi", 32'(mem[18'h3FFFF]), 32'h0000A5A5);

        rd_en = 1'b1;
        address = 32'd1036;
        #1;
        chk("rst_ready_c0", 32'(ready), 32'd0);
        for (int k = 1; k <= 5; k++) step();
        chk("rst_saddr_hi", 32'(sram_addr), 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_en = 1'b0;
        #1;
        idle_chk("rst_mid", 32'h0, 18'h0);
        step();
        idle_chk("rst_mid2", 32'h0, 18'h0);
        access("ld_after_rst", 1'b1, 1'b0, 32'd1036, 32'h0, 18'd6, 32'h0, 32'h12345678);
        release_req();
        idle_chk("final", 32'h12345678, 18'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
